// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port strobe-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 8;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter: round-robin against the last winner, or fixed priority to port 0.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = P_FETCH;
        if (req == 2'b11) begin
            gnt = mode ? ~last : P_FETCH;
        end else if (req[1]) begin
            gnt = P_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one asynchronous-strobe memory between fetch (port 0) and data (port 1),
// sequencing each access as SETUP / STROBE / HOLD with registered strobes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_dout,
    output logic          mem_dout_en,
    input  logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          grant
);

    localparam logic ARB_MODE = (RR != 0);

    state_t        state_q, state_d;
    logic          we_q;
    logic          rr_last_q;
    logic          arb_gnt, arb_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          latch_c;
    logic          mem_read_d, mem_write_d, dout_en_d;
    logic          ack0_d, ack1_d, busy_d;

    rr_arb2 u_arb (
        .req   ({p1_req, p0_req}),
        .last  (rr_last_q),
        .mode  (ARB_MODE),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Request payload of whichever port the arbiter picked
    always_comb begin
        sel_we    = (arb_gnt == P_DATA) ? p1_we    : p0_we;
        sel_addr  = (arb_gnt == P_DATA) ? p1_addr  : p0_addr;
        sel_wdata = (arb_gnt == P_DATA) ? p1_wdata : p0_wdata;
    end

    // Next state plus the strobe/ack values to register for that state
    always_comb begin
        state_d     = state_q;
        latch_c     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        dout_en_d   = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    latch_c    = 1'b1;
                    state_d    = SETUP;
                    mem_read_d = ~sel_we;
                    dout_en_d  = sel_we;
                end
            end
            SETUP: begin
                state_d     = STROBE;
                mem_read_d  = ~we_q;
                mem_write_d = we_q;
                dout_en_d   = we_q;
            end
            STROBE: begin
                state_d   = HOLD;
                dout_en_d = we_q;
                ack0_d    = (grant == P_FETCH);
                ack1_d    = (grant == P_DATA);
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            rr_last_q   <= 1'b1;
            grant       <= 1'b0;
            mem_addr    <= '0;
            mem_dout    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_dout_en <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read    <= mem_read_d;
            mem_write   <= mem_write_d;
            mem_dout_en <= dout_en_d;
            p0_ack      <= ack0_d;
            p1_ack      <= ack1_d;
            busy        <= busy_d;
            if (latch_c) begin
                we_q     <= sel_we;
                mem_addr <= sel_addr;
                mem_dout <= sel_wdata;
                grant    <= arb_gnt;
            end
            // Read data is taken as the read strobe ends
            if (state_q == STROBE && !we_q) begin
                if (grant == P_DATA) begin
                    p1_rdata <= mem_din;
                end else begin
                    p0_rdata <= mem_din;
                end
            end
            if (state_q == HOLD) begin
                rr_last_q <= grant;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: round-robin instance on a behavioural 32x8
// memory, plus a fixed-priority instance for the priority scenario.
module tb_mem_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [4:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_ack, p1_ack;
    logic [7:0] p0_rdata, p1_rdata;
    logic [4:0] mem_addr;
    logic       mem_read, mem_write, mem_dout_en, busy, grant;
    logic [7:0] mem_dout, mem_din;

    logic       f_p0_req, f_p1_req, f_p0_ack, f_p1_ack;
    logic [7:0] f_p0_rdata, f_p1_rdata, f_mem_dout, f_mem_din;
    logic [4:0] f_mem_addr;
    logic       f_mem_read, f_mem_write, f_mem_dout_en, f_busy, f_grant;

    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];

    sb_t        q0[$], q1[$];
    logic [7:0] last_rd0 = 8'h00, last_rd1 = 8'h00;
    int         n_chk = 0, n_err = 0;
    int         cyc = 0, ack_cnt = 0;
    bit         log_on = 1'b0;
    int         log_port[$], log_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.AW(5), .DW(8), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din),
        .busy(busy), .grant(grant)
    );

    mem_arbiter #(.AW(5), .DW(8), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_p0_req), .p0_we(1'b0), .p0_addr(5'd1), .p0_wdata(8'd0),
        .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
        .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(5'd2), .p1_wdata(8'd0),
        .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
        .mem_addr(f_mem_addr), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_dout(f_mem_dout), .mem_dout_en(f_mem_dout_en), .mem_din(f_mem_din),
        .busy(f_busy), .grant(f_grant)
    );

    // Behavioural memory: the write is taken while the strobe is high
    assign mem_din   = mem_read ? mem[mem_addr] : 8'h00;
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_dout;
    assign f_mem_din = f_mem_read ? (8'(f_mem_addr) ^ 8'h5A) : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input int p);
        sb_t e;
        if (p == 0) begin
            if (q0.size() == 0) begin
                check("p0_unexpected_ack", 32'd1, 32'd0);
                return;
            end
            e = q0.pop_front();
            if (!e.we) begin
                check("p0_rdata", 32'(p0_rdata), 32'(e.data));
                last_rd0 = e.data;
            end
            check("p1_rdata_held", 32'(p1_rdata), 32'(last_rd1));
        end else begin
            if (q1.size() == 0) begin
                check("p1_unexpected_ack", 32'd1, 32'd0);
                return;
            end
            e = q1.pop_front();
            if (!e.we) begin
                check("p1_rdata", 32'(p1_rdata), 32'(e.data));
                last_rd1 = e.data;
            end
            check("p0_rdata_held", 32'(p0_rdata), 32'(last_rd0));
        end
        if (log_on) begin
            log_port.push_back(p);
            log_cyc.push_back(cyc);
        end
    endtask

    // Per-cycle bus monitor and ack scoreboard
    initial begin
        int  wcnt;
        bit  prev_den;
        wcnt = 0;
        prev_den = 1'b0;
        forever begin
            @(negedge clk);
            check("no_dout_en_with_read", 32'(mem_dout_en & mem_read), 32'd0);
            check("no_read_with_write", 32'(mem_write & mem_read), 32'd0);
            if (p0_ack && p1_ack) check("dual_ack", 32'd1, 32'd0);
            if (p0_ack) begin ack_cnt++; sb_pop(0); end
            if (p1_ack) begin ack_cnt++; sb_pop(1); end
            if (mem_write) begin
                if (wcnt == 0) check("wr_data_setup", 32'(prev_den), 32'd1);
                check("wr_dout_en", 32'(mem_dout_en), 32'd1);
                wcnt++;
            end else if (wcnt != 0) begin
                check("wr_pulse_width", 32'(wcnt), 32'd1);
                if (busy) check("wr_data_hold", 32'(mem_dout_en), 32'd1);
                wcnt = 0;
            end
            prev_den = mem_dout_en;
        end
    end

    // One transaction: caller is at a negedge; returns at the ack negedge
    task automatic op(input int p, input logic we, input logic [4:0] a,
                      input logic [7:0] d, output int waits);
        sb_t e;
        bit  seen;
        e.we   = we;
        e.data = we ? d : ref_mem[a];
        if (we) ref_mem[a] = d;
        if (p == 0) begin
            q0.push_back(e);
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            q1.push_back(e);
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        end
        waits = 0;
        seen  = 1'b0;
        while (!seen && waits < 40) begin
            @(negedge clk);
            waits++;
            seen = (p == 0) ? p0_ack : p1_ack;
        end
        check((p == 0) ? "p0_ack_seen" : "p1_ack_seen", 32'(seen), 32'd1);
        if (p == 0) p0_req = 1'b0;
        else        p1_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w, tot, a0, fcnt;
        bit seen;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        f_p0_req = 1'b0; f_p1_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write, mem_dout_en}), 32'd0);
        check("rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
        check("rst_addr_dout", 32'({mem_addr, mem_dout}), 32'd0);
        rst_n = 1'b1;

        // Single write then read on port 1
        @(negedge clk);
        op(1, 1'b1, 5'h03, 8'hA5, w);
        check("wr_latency", 32'(w), 32'd3);
        @(negedge clk);
        op(1, 1'b0, 5'h03, 8'h00, w);
        check("rd_latency", 32'(w), 32'd3);
        check("p1_rdata_a5", 32'(p1_rdata), 32'hA5);

        // Cross-port write then read of the same address
        @(negedge clk);
        op(0, 1'b1, 5'h07, 8'hC3, w);
        op(1, 1'b0, 5'h07, 8'h00, w);
        check("xport_rdata", 32'(p1_rdata), 32'hC3);

        // Fill and read back all 32 locations back-to-back on port 0
        @(negedge clk);
        a0  = ack_cnt;
        tot = 0;
        for (int i = 0; i < 32; i++) begin op(0, 1'b1, 5'(i), 8'(i), w); tot += w; end
        for (int i = 0; i < 32; i++) begin op(0, 1'b0, 5'(i), 8'h00, w); tot += w; end
        @(negedge clk);
        check("fill_acks", 32'(ack_cnt - a0), 32'd64);
        check("fill_cycles", 32'(tot + 1), 32'd256);

        // Reset asserted during the write strobe
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'h10; p1_wdata = 8'h3C;
        repeat (2) @(negedge clk);
        check("midrst_in_strobe", 32'(mem_write), 32'd1);
        rst_n  = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        check("midrst_strobes", 32'({mem_read, mem_write, mem_dout_en}), 32'd0);
        check("midrst_acks", 32'({p0_ack, p1_ack}), 32'd0);
        check("midrst_busy_grant", 32'({busy, grant}), 32'd0);
        check("midrst_addr_dout", 32'({mem_addr, mem_dout}), 32'd0);
        check("midrst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
        last_rd0 = 8'h00;
        last_rd1 = 8'h00;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        op(1, 1'b1, 5'h10, 8'h77, w);
        check("postrst_wr_latency", 32'(w), 32'd3);
        @(negedge clk);
        op(1, 1'b0, 5'h10, 8'h00, w);
        check("postrst_rd_latency", 32'(w), 32'd3);

        // Round-robin with both ports reading continuously
        @(negedge clk);
        log_on = 1'b1;
        fork
            begin
                int wa;
                for (int k = 0; k < 4; k++) op(0, 1'b0, 5'(k), 8'h00, wa);
            end
            begin
                int wb;
                for (int k = 0; k < 4; k++) op(1, 1'b0, 5'(k + 8), 8'h00, wb);
            end
        join
        @(negedge clk);
        log_on = 1'b0;
        check("rr_ack_count", 32'(log_port.size()), 32'd8);
        for (int i = 0; i < log_port.size(); i++) begin
            check("rr_order", 32'(log_port[i]), 32'(i % 2));
            if (i > 0) check("rr_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd4);
        end

        // Fixed priority instance: port 1 starved while port 0 keeps requesting
        f_p0_req = 1'b1;
        f_p1_req = 1'b1;
        fcnt = 0;
        repeat (16) begin
            @(negedge clk);
            check("fp_p1_blocked", 32'(f_p1_ack), 32'd0);
            if (f_p0_ack) fcnt++;
        end
        check("fp_p0_acks", 32'(fcnt), 32'd4);
        check("fp_p0_rdata", 32'(f_p0_rdata), 32'h5B);
        f_p0_req = 1'b0;
        seen = 1'b0;
        w = 0;
        while (!seen && w < 4) begin
            @(negedge clk);
            w++;
            seen = f_p1_ack;
        end
        check("fp_p1_served", 32'(seen), 32'd1);
        check("fp_p1_rdata", 32'(f_p1_rdata), 32'h58);
        f_p1_req = 1'b0;

        // Random mixed traffic on both ports; disjoint address halves keep the model exact
        @(negedge clk);
        a0 = cyc;
        fork
            begin
                int wa;
                while (cyc < a0 + 1000) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    op(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 8'($urandom), wa);
                end
            end
            begin
                int wb;
                while (cyc < a0 + 1000) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    op(1, 1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)), 8'($urandom), wb);
                end
            end
        join
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
